// File: rtl/sp2_fb_flip_ctrl_if.sv
// Writer-client handshake and back-bank RAM write port for sp2_fb_flip_ctrl.
// Latency: none (wiring only); grant is combinational from the controller.
// Backpressure: clients hold req/addr/data stable until they see their gnt.
interface sp2_fb_flip_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              c0_req;
    logic              c1_req;
    logic [ADDR_W-1:0] c0_addr;
    logic [ADDR_W-1:0] c1_addr;
    logic [15:0]       c0_data;
    logic [15:0]       c1_data;
    logic              c0_gnt;
    logic              c1_gnt;
    logic              wr_en;
    logic [ADDR_W:0]   wr_addr;
    logic [15:0]       wr_data;
    logic              wr_err;

    modport master (
        output c0_req, c1_req, c0_addr, c1_addr, c0_data, c1_data,
        input  c0_gnt, c1_gnt, wr_en, wr_addr, wr_data, wr_err
    );

    modport slave (
        input  c0_req, c1_req, c0_addr, c1_addr, c0_data, c1_data,
        output c0_gnt, c1_gnt, wr_en, wr_addr, wr_data, wr_err
    );
endinterface

// File: rtl/sp2_fb_flip_ctrl.sv
// Double-buffer page flip + round-robin back-bank write arbiter; SP2_FB_AUTOCLEAR_EN adds a post-swap fill engine.
// Latency: grant same cycle, write port registered 1 cycle later; swap 1 cycle after frame_done.
// Backpressure: grants withheld while a flip is pending, during the swap cycle and while clearing.
module sp2_fb_flip_ctrl #(
    parameter int PIX_COUNT = 55040,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_done,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [ADDR_W:0]   rd_addr,
    output logic              disp_bank,
    input  logic              flip_req,
    output logic              flip_pending,
    output logic              flip_ack,
    input  logic [15:0]       fill_color,
    output logic              busy,
    output logic              clear_done,
    sp2_fb_flip_ctrl_if.slave wb
);

    typedef enum logic [1:0] {IDLE, PEND, CLEAR} state_t;

`ifdef SP2_FB_AUTOCLEAR_EN
    localparam state_t SWAP_NXT = CLEAR;
`else
    localparam state_t SWAP_NXT = IDLE;
`endif

    state_t            state, state_nxt;
    logic              pend_nxt;
    logic              swap;
    logic              rr_last;
    logic              grant_en;
    logic              g0, g1;
    logic [ADDR_W-1:0] sel_addr;
    logic [15:0]       sel_data;
    logic              in_range;
    logic              wr_en_q, wr_err_q;
    logic [ADDR_W:0]   wr_addr_q;
    logic [15:0]       wr_data_q;

`ifdef SP2_FB_AUTOCLEAR_EN
    logic [ADDR_W-1:0] clr_cnt;
    logic [15:0]       fill_q;
    logic              busy_q, done_q;
    logic              clr_wr, clr_last;
    assign clr_last   = (clr_cnt == ADDR_W'(PIX_COUNT - 1));
    assign busy       = busy_q;
    assign clear_done = done_q;
`else
    logic unused_fill;
    assign unused_fill = ^fill_color;
    assign busy        = 1'b0;
    assign clear_done  = 1'b0;
`endif

    assign rd_addr = {disp_bank, disp_addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            flip_pending <= 1'b0;
            flip_ack     <= 1'b0;
            disp_bank    <= 1'b0;
        end else begin
            state        <= state_nxt;
            flip_pending <= pend_nxt;
            flip_ack     <= swap;
            disp_bank    <= disp_bank ^ swap;
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = flip_pending;
        swap      = 1'b0;
`ifdef SP2_FB_AUTOCLEAR_EN
        clr_wr    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (flip_req && frame_done) begin
                    swap      = 1'b1;
                    state_nxt = SWAP_NXT;
                end else if (flip_req) begin
                    pend_nxt  = 1'b1;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                if (frame_done) begin
                    swap      = 1'b1;
                    pend_nxt  = 1'b0;
                    state_nxt = SWAP_NXT;
                end
            end
`ifdef SP2_FB_AUTOCLEAR_EN
            CLEAR: begin
                clr_wr = 1'b1;
                if (flip_req)
                    pend_nxt = 1'b1;
                if (clr_last)
                    state_nxt = pend_nxt ? PEND : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // The swap cycle and the cycle after it are also blocked so no write
    // can straddle the bank change and land in the bank being displayed.
    assign grant_en = (state == IDLE) && !busy && !flip_ack && !(flip_req && frame_done);
    assign g0 = grant_en && wb.c0_req && (!wb.c1_req || rr_last);
    assign g1 = grant_en && wb.c1_req && (!wb.c0_req || !rr_last);
    assign wb.c0_gnt = g0;
    assign wb.c1_gnt = g1;

    assign sel_addr = g1 ? wb.c1_addr : wb.c0_addr;
    assign sel_data = g1 ? wb.c1_data : wb.c0_data;
    assign in_range = ({1'b0, sel_addr} < (ADDR_W + 1)'(PIX_COUNT));

    // rr_last holds the last winner; resetting to 1 lets c0 win first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_last <= 1'b1;
        else if (g0)
            rr_last <= 1'b0;
        else if (g1)
            rr_last <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_err_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q  <= 1'b0;
            wr_err_q <= 1'b0;
`ifdef SP2_FB_AUTOCLEAR_EN
            if (clr_wr) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= {~disp_bank, clr_cnt};
                wr_data_q <= fill_q;
            end else
`endif
            if (g0 || g1) begin
                wr_en_q   <= in_range;
                wr_err_q  <= !in_range;
                wr_addr_q <= {~disp_bank, sel_addr};
                wr_data_q <= sel_data;
            end
        end
    end

`ifdef SP2_FB_AUTOCLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_cnt <= '0;
            fill_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= clr_wr && clr_last;
            if (done_q)
                busy_q <= 1'b0;
            if (swap) begin
                clr_cnt <= '0;
                fill_q  <= fill_color;
                busy_q  <= 1'b1;
            end else if (clr_wr) begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
            end
        end
    end
`endif

    assign wb.wr_en   = wr_en_q;
    assign wb.wr_err  = wr_err_q;
    assign wb.wr_addr = wr_addr_q;
    assign wb.wr_data = wr_data_q;

endmodule

// File: tb/tb_sp2_fb_flip_ctrl.sv
// Directed vector table for arbitration plus hand sequences for flip, clear and async reset.
module tb_sp2_fb_flip_ctrl;
    localparam int ADDR_W = 16;
    localparam int PIX    = 55040;

    logic              clk, rst_n, frame_done, flip_req;
    logic              disp_bank, flip_pending, flip_ack, busy, clear_done;
    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W:0]   rd_addr;
    logic [15:0]       fill_color;

    sp2_fb_flip_ctrl_if #(.ADDR_W(ADDR_W)) wb();

    sp2_fb_flip_ctrl #(.PIX_COUNT(PIX), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_done   (frame_done),
        .disp_addr    (disp_addr),
        .rd_addr      (rd_addr),
        .disp_bank    (disp_bank),
        .flip_req     (flip_req),
        .flip_pending (flip_pending),
        .flip_ack     (flip_ack),
        .fill_color   (fill_color),
        .busy         (busy),
        .clear_done   (clear_done),
        .wb           (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        c0_req;
        logic [15:0] c0_addr;
        logic [15:0] c0_data;
        logic        c1_req;
        logic [15:0] c1_addr;
        logic [15:0] c1_data;
        logic        g0;
        logic        g1;
        logic        en;
        logic        err;
        logic [16:0] waddr;
        logic [15:0] wdata;
    } vec_t;

    vec_t vecs[10];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int errs;

        vecs[0] = '{1'b1, 16'd10, 16'hAAAA, 1'b1, 16'd20, 16'hBBBB, 1'b1, 1'b0, 1'b1, 1'b0, 17'h1000A, 16'hAAAA};
        vecs[1] = '{1'b1, 16'd10, 16'hAAAA, 1'b1, 16'd20, 16'hBBBB, 1'b0, 1'b1, 1'b1, 1'b0, 17'h10014, 16'hBBBB};
        vecs[2] = '{1'b1, 16'd10, 16'hAAAA, 1'b1, 16'd20, 16'hBBBB, 1'b1, 1'b0, 1'b1, 1'b0, 17'h1000A, 16'hAAAA};
        vecs[3] = '{1'b1, 16'd10, 16'hAAAA, 1'b1, 16'd20, 16'hBBBB, 1'b0, 1'b1, 1'b1, 1'b0, 17'h10014, 16'hBBBB};
        vecs[4] = '{1'b1, 16'd5,  16'hF800, 1'b0, 16'd0,  16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 17'h10005, 16'hF800};
        vecs[5] = '{1'b0, 16'd0,  16'h0000, 1'b1, 16'hD700, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 17'h0, 16'h0};
        vecs[6] = '{1'b0, 16'd0,  16'h0000, 1'b0, 16'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 17'h0, 16'h0};
        vecs[7] = '{1'b0, 16'd0,  16'h0000, 1'b1, 16'hD6FF, 16'h5555, 1'b0, 1'b1, 1'b1, 1'b0, 17'h1D6FF, 16'h5555};
        vecs[8] = '{1'b1, 16'd0,  16'h0001, 1'b1, 16'd3,  16'h0003, 1'b1, 1'b0, 1'b1, 1'b0, 17'h10000, 16'h0001};
        vecs[9] = '{1'b0, 16'd0,  16'h0000, 1'b1, 16'hFFFF, 16'h7777, 1'b0, 1'b1, 1'b0, 1'b1, 17'h0, 16'h0};

        rst_n = 1'b0; frame_done = 1'b0; flip_req = 1'b0;
        disp_addr = 16'h0042; fill_color = 16'h001F;
        wb.c0_req = 1'b0; wb.c1_req = 1'b0;
        wb.c0_addr = '0; wb.c1_addr = '0; wb.c0_data = '0; wb.c1_data = '0;

        #12;
        check("rst_disp_bank", disp_bank, 0);
        check("rst_flip_pending", flip_pending, 0);
        check("rst_flip_ack", flip_ack, 0);
        check("rst_wr_en", wb.wr_en, 0);
        check("rst_wr_err", wb.wr_err, 0);
        check("rst_wr_addr", wb.wr_addr, 0);
        check("rst_wr_data", wb.wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_clear_done", clear_done, 0);
        check("rst_rd_addr", rd_addr, 17'h00042);
        #10 rst_n = 1'b1;
        tick();

        for (int k = 0; k < 10; k++) begin
            wb.c0_req = vecs[k].c0_req; wb.c0_addr = vecs[k].c0_addr; wb.c0_data = vecs[k].c0_data;
            wb.c1_req = vecs[k].c1_req; wb.c1_addr = vecs[k].c1_addr; wb.c1_data = vecs[k].c1_data;
            #1;
            check($sformatf("v%0d_c0_gnt", k), wb.c0_gnt, vecs[k].g0);
            check($sformatf("v%0d_c1_gnt", k), wb.c1_gnt, vecs[k].g1);
            tick();
            check($sformatf("v%0d_wr_en", k), wb.wr_en, vecs[k].en);
            check($sformatf("v%0d_wr_err", k), wb.wr_err, vecs[k].err);
            if (vecs[k].en) begin
                check($sformatf("v%0d_wr_addr", k), wb.wr_addr, vecs[k].waddr);
                check($sformatf("v%0d_wr_data", k), wb.wr_data, vecs[k].wdata);
            end
        end
        wb.c0_req = 1'b0; wb.c1_req = 1'b0;

        // Flip request, then frame_done ten cycles later with a writer waiting.
        flip_req = 1'b1;
        tick();
        flip_req = 1'b0;
        wb.c0_req = 1'b1; wb.c0_addr = 16'd7; wb.c0_data = 16'h0707;
        check("flip_pending_set", flip_pending, 1);
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (wb.c0_gnt !== 1'b0) errs++;
            tick();
        end
        check("gnt_frozen_pend", errs, 0);
        frame_done = 1'b1; disp_addr = 16'h0123;
        #1;
        check("gnt_at_frame_done", wb.c0_gnt, 0);
        tick();
        frame_done = 1'b0;
        #1;
        check("swap_disp_bank", disp_bank, 1);
        check("swap_flip_ack", flip_ack, 1);
        check("swap_pending_clr", flip_pending, 0);
        check("swap_rd_addr", rd_addr, 17'h10123);
        check("gnt_swap_cycle", wb.c0_gnt, 0);

`ifndef SP2_FB_AUTOCLEAR_EN
        tick();
        check("gnt_after_swap", wb.c0_gnt, 1);
        check("flip_ack_one_cycle", flip_ack, 0);
        tick();
        check("post_swap_wr_en", wb.wr_en, 1);
        check("post_swap_wr_addr", wb.wr_addr, 17'h00007);
        check("post_swap_wr_data", wb.wr_data, 16'h0707);
        wb.c0_req = 1'b0;

        flip_req = 1'b1; frame_done = 1'b1;
        tick();
        flip_req = 1'b0; frame_done = 1'b0;
        check("same_cycle_disp_bank", disp_bank, 0);
        check("same_cycle_flip_ack", flip_ack, 1);
        check("same_cycle_pending", flip_pending, 0);

        flip_req = 1'b1;
        tick();
        flip_req = 1'b0;
        repeat (3) tick();
        check("pend_before_rst", flip_pending, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pending", flip_pending, 0);
        check("async_rst_busy", busy, 0);
`else
        check("clear_busy_start", busy, 1);
        wb.c0_req = 1'b0;
        tick();
        errs = 0;
        for (int i = 0; i < PIX; i++) begin
            if (wb.wr_en !== 1'b1 || wb.wr_addr !== 17'(i) || wb.wr_data !== 16'h001F ||
                clear_done !== (i == PIX - 1) || busy !== 1'b1 || wb.c1_gnt !== 1'b0)
                errs++;
            flip_req = (i == 1000);
            if (i == 500) fill_color = 16'hFFFF;
            if (i != PIX - 1) tick();
        end
        check("clear_writes", errs, 0);
        check("clear_done_last", clear_done, 1);
        check("flip_latched_mid_clear", flip_pending, 1);
        tick();
        check("busy_after_clear", busy, 0);
        check("clear_done_pulse", clear_done, 0);
        check("wr_en_after_clear", wb.wr_en, 0);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check("second_swap_bank", disp_bank, 0);
        check("second_swap_ack", flip_ack, 1);
        check("second_clear_busy", busy, 1);
        repeat (100) tick();
        check("clear_in_progress_addr", wb.wr_addr, 17'h10063);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_wr_en", wb.wr_en, 0);
        check("async_rst_disp_bank", disp_bank, 0);
        check("async_rst_pending", flip_pending, 0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        wb.c1_req = 1'b1; wb.c1_addr = 16'd9; wb.c1_data = 16'h9999;
        #1;
        check("post_rst_c1_gnt", wb.c1_gnt, 1);
        tick();
        wb.c1_req = 1'b0;
        check("post_rst_wr_en", wb.wr_en, 1);
        check("post_rst_wr_addr", wb.wr_addr, 17'h10009);
        check("post_rst_wr_data", wb.wr_data, 16'h9999);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sp2_fb_flip_ctrl.md
# sp2_fb_flip_ctrl

Double-buffer page-flip controller and write-port arbiter for the SP2 320x172 LCD framebuffer. It owns a two-bank RGB565 framebuffer RAM. The SPI display driver's read address is steered to the front bank, and two pixel writers share the single back-bank write port under round-robin arbitration. Bank swaps happen only at the driver's `frame_done` boundary, so the panel never shows a torn frame. An optional engine fills the new back bank with a fill colour after each swap.

## Interface
Parameters:
- `PIX_COUNT`, 55040, pixels per bank (320x172).
- `ADDR_W`, 16, pixel address width per bank.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame_done`  in  1  one-cycle pulse from the SPI driver at the end of each frame.
- `disp_addr`  in  ADDR_W  driver pixel read address.
- `rd_addr`  out  ADDR_W+1  RAM read address, `{disp_bank, disp_addr}` (combinational).
- `disp_bank`  out  1  bank currently displayed.
- `flip_req`  in  1  pulse: request a swap at the next frame boundary.
- `flip_pending`  out  1  swap requested, not yet performed.
- `flip_ack`  out  1  one-cycle pulse in the cycle `disp_bank` changes.
- `c0_req`, `c1_req`  in  1  writer requests.
- `c0_addr`, `c1_addr`  in  ADDR_W  writer pixel addresses.
- `c0_data`, `c1_data`  in  16  writer RGB565 data.
- `c0_gnt`, `c1_gnt`  out  1  grant (combinational).
- `fill_color`  in  16  colour used by the clear engine.
- `wr_en`  out  1  RAM write strobe (registered).
- `wr_addr`  out  ADDR_W+1  RAM write address, `{back bank, pixel}`.
- `wr_data`  out  16  RAM write data.
- `wr_err`  out  1  one-cycle pulse: a granted write was dropped as out of range.
- `busy`  out  1  clear in progress.
- `clear_done`  out  1  one-cycle pulse when a clear completes.

Reset values: every registered output is 0, including `disp_bank`, `flip_pending`, `flip_ack`, `wr_*`, `wr_err`, `busy` and `clear_done`. The round-robin pointer resets so that `c0` wins the first contended cycle.

## Operation
- States: `IDLE`, `PEND` (flip pending), `CLEAR` (macro builds only).
- `IDLE` → `PEND`:
  - Triggered by `flip_req`; `flip_pending` is set.
  - If `flip_req` and `frame_done` arrive in the same cycle, the swap happens on that `frame_done`.
- `PEND`, on `frame_done`:
  - `disp_bank` toggles and `flip_ack` pulses; `flip_pending` clears.
  - Next state is `CLEAR` when the macro is built in, `IDLE` otherwise.
- `flip_req` while already pending: ignored. There is only one pending flip.
- `flip_req` during `CLEAR`: latched into `flip_pending`. It takes effect at the first `frame_done` after the clear completes.
- Grants are forced to 0 in `PEND` and `CLEAR`, which freezes the back bank until the swap and fill finish.
- Arbitration in `IDLE`:
  - A single requester is granted in the same cycle.
  - When both request, grant goes to the client not granted last; the pointer updates on every grant.
- A transfer occurs in any cycle where `cX_req & cX_gnt`. Clients hold `req`, `addr` and `data` stable until granted.
- Write target: `{~disp_bank, cX_addr}`.
  - If `cX_addr >= PIX_COUNT`, the grant is still given, but `wr_en` stays 0 and `wr_err` pulses.
- `CLEAR`:
  - Writes `fill_color` (sampled once on entry) to pixels 0..PIX_COUNT-1 of the new back bank, one per cycle.
  - `busy` is high throughout; `clear_done` pulses with the final write.
- `rd_addr` follows `disp_bank` immediately.
  - This is safe because the driver sends 11 window bytes after `frame_done` before it reads pixel 0.

## Timing
- Client grant → `wr_en`/`wr_addr`/`wr_data`: 1 cycle latency. Throughput is 1 write per cycle.
- `frame_done` sampled high in cycle N (with flip pending):
  - Cycle N+1: `disp_bank` toggled, `flip_ack`=1, `busy`=1.
  - First clear write appears on `wr_*` in cycle N+2; last write in cycle N+1+PIX_COUNT, with `clear_done`.
  - `busy` drops after cycle N+1+PIX_COUNT; grants are possible from cycle N+2+PIX_COUNT.
- Clear time is 55040 cycles (1.1 ms), well inside one SPI frame (~1.76 M cycles).
- Asserting `rst_n` mid-clear or mid-pending aborts immediately and returns all outputs to reset values. The partially cleared bank is not restored.

## Configuration
- `SP2_FB_AUTOCLEAR_EN` defined: the `CLEAR` state and address counter are built, and `busy`/`clear_done` behave as above.
- Undefined: `PEND` returns directly to `IDLE` on the swap, `busy` and `clear_done` are tied to 0, and clients are granted from cycle N+2.

## Test plan
- Reset, then `c0_req` with addr 5, data 16'hF800 → `c0_gnt`=1 in the same cycle; next cycle `wr_en`=1, `wr_addr`=17'h10005, `wr_data`=16'hF800.
- `c0_req` and `c1_req` held for 4 cycles → grants c0, c1, c0, c1; exactly one `wr_en` per cycle.
- `flip_req`, then `frame_done` 10 cycles later → grants 0 for those 10 cycles; `disp_bank` 0→1 and `flip_ack` one cycle after `frame_done`; `rd_addr`=`{1,disp_addr}`.
- AUTOCLEAR with `fill_color`=16'h001F → 55040 consecutive writes to addresses 17'h00000..17'h0D6FF with data 16'h001F; `clear_done` on the last one; a `flip_req` pulsed mid-clear swaps at the next `frame_done`.
- `c1_addr`=55040 granted → `wr_en` stays 0, `wr_err` pulses once.
- Reset asserted 100 cycles into a clear → `busy`, `wr_en` and `disp_bank` return to 0 asynchronously; normal arbitration resumes after release.
